// File: rtl/tach_sequencer.sv
// tach_sequencer: round-robin period measurement over up to four tach inputs.
// One shared ms timebase and period counter; results leave via valid/ack.
module tach_sequencer #(
  parameter int N_CH     = 4,
  parameter int COUNT_MS = 50000,
  parameter int W        = 10,
  parameter int MAX_MS   = 1023
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] pulse_in,
  input  logic            enable,
  input  logic            result_ack,
  output logic [W-1:0]    result_data,
  output logic [1:0]      result_ch,
  output logic            result_timeout,
  output logic            result_valid,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEASURE,
    PUBLISH
  } state_t;

  state_t state_q, state_d;

  logic [N_CH-1:0] s1_q, s1_d;
  logic [N_CH-1:0] s2_q, s2_d;
  logic [N_CH-1:0] prev_q, prev_d;
  logic [N_CH-1:0] rise;

  logic [1:0]   ch_q, ch_d;
  logic [15:0]  treg_q, treg_d;
  logic [W-1:0] pcnt_q, pcnt_d;
  logic [W-1:0] rdata_q, rdata_d;
  logic [1:0]   rch_q, rch_d;
  logic         rto_q, rto_d;

  logic rise_sel;
  logic tick;
  logic sat;

  always_comb begin
    s1_d   = pulse_in;
    s2_d   = s1_q;
    prev_d = s2_q;
  end

  assign rise = s2_q & ~prev_q;
  assign tick = (treg_q == 16'(COUNT_MS - 1));
  assign sat  = (pcnt_q == W'(MAX_MS));

  always_comb begin
    rise_sel = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (ch_q == 2'(i)) rise_sel = rise[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      s1_q    <= '0;
      s2_q    <= '0;
      prev_q  <= '0;
      ch_q    <= '0;
      treg_q  <= '0;
      pcnt_q  <= '0;
      rdata_q <= '0;
      rch_q   <= '0;
      rto_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      prev_q  <= prev_d;
      ch_q    <= ch_d;
      treg_q  <= treg_d;
      pcnt_q  <= pcnt_d;
      rdata_q <= rdata_d;
      rch_q   <= rch_d;
      rto_q   <= rto_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (enable) state_d = ARM;
      end
      ARM: begin
        if (rise_sel)        state_d = MEASURE;
        else if (tick && sat) state_d = PUBLISH;
      end
      MEASURE: begin
        if (rise_sel || (tick && sat)) state_d = PUBLISH;
      end
      PUBLISH: begin
        if (result_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The selected edge always beats a coincident tick.
  always_comb begin
    treg_d  = treg_q;
    pcnt_d  = pcnt_q;
    rdata_d = rdata_q;
    rch_d   = rch_q;
    rto_d   = rto_q;
    ch_d    = ch_q;
    unique case (state_q)
      IDLE: begin
        treg_d = '0;
        pcnt_d = '0;
      end
      ARM, MEASURE: begin
        if (rise_sel) begin
          treg_d = '0;
          pcnt_d = '0;
          if (state_q == MEASURE) begin
            rdata_d = pcnt_q;
            rch_d   = ch_q;
            rto_d   = 1'b0;
          end
        end else if (tick) begin
          treg_d = '0;
          if (sat) begin
            rdata_d = W'(MAX_MS);
            rch_d   = ch_q;
            rto_d   = 1'b1;
          end else begin
            pcnt_d = pcnt_q + W'(1);
          end
        end else begin
          treg_d = treg_q + 16'd1;
        end
      end
      PUBLISH: begin
        if (result_ack) begin
          ch_d = (ch_q == 2'(N_CH - 1)) ? 2'd0 : ch_q + 2'd1;
        end
      end
      default: begin
        treg_d = '0;
        pcnt_d = '0;
      end
    endcase
  end

  always_comb begin
    busy           = (state_q != IDLE);
    result_valid   = (state_q == PUBLISH);
    result_data    = rdata_q;
    result_ch      = rch_q;
    result_timeout = rto_q;
  end

endmodule

// File: tb/tb_tach_sequencer.sv
// tb_tach_sequencer: random pulse trains against an edge-timeline model,
// plus directed handshake, timeout, reset and enable scenarios.
module tb_tach_sequencer;

  localparam int NCH   = 4;
  localparam int CMS   = 10;
  localparam int WW    = 4;
  localparam int MAXMS = 15;
  localparam int H     = 5000;
  localparam int TMO   = (MAXMS + 1) * CMS;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           enable = 1'b0;
  logic           result_ack = 1'b0;
  logic [NCH-1:0] pulse_in = '0;
  logic [WW-1:0]  result_data;
  logic [1:0]     result_ch;
  logic           result_timeout;
  logic           result_valid;
  logic           busy;

  int total = 0;
  int bad = 0;
  int per[NCH];
  int ph[NCH];
  int hw[NCH];
  int hand[4] = '{2, 3, 4, 9};

  typedef struct {
    int pub;
    int ch;
    int data;
    int to;
  } exp_t;
  exp_t q[$];

  tach_sequencer #(
    .N_CH(NCH), .COUNT_MS(CMS), .W(WW), .MAX_MS(MAXMS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pulse_in(pulse_in),
    .enable(enable),
    .result_ack(result_ack),
    .result_data(result_data),
    .result_ch(result_ch),
    .result_timeout(result_timeout),
    .result_valid(result_valid),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog got=stuck exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic bit pin_at(int c, int u);
    if (per[c] == 0 || u < ph[c]) return 1'b0;
    return ((u - ph[c]) % per[c]) < hw[c];
  endfunction

  // Pin rise at cycle u is seen by the controller at u+2.
  function automatic bit rise_at(int c, int u);
    return pin_at(c, u - 2) && !pin_at(c, u - 3);
  endfunction

  task automatic build_model();
    int e, c, r, b;
    exp_t x;
    q.delete();
    e = 1;
    c = 0;
    forever begin
      r = -1;
      for (int t = e; t < e + TMO; t++)
        if (r < 0 && rise_at(c, t)) r = t;
      if (r < 0) begin
        x.pub = e + TMO; x.data = MAXMS; x.to = 1;
      end else begin
        b = -1;
        for (int t = r + 1; t <= r + TMO; t++)
          if (b < 0 && rise_at(c, t)) b = t;
        if (b < 0) begin
          x.pub = r + TMO + 1; x.data = MAXMS; x.to = 1;
        end else begin
          x.pub = b + 1; x.data = (b - r - 1) / CMS; x.to = 0;
        end
      end
      if (x.pub >= H) break;
      x.ch = c;
      q.push_back(x);
      c = (c + 1) % NCH;
      e = x.pub + 2;
    end
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int c);
    pulse_in[c] = 1'b1;
    gap(3);
    pulse_in[c] = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    pulse_in = '0;
    enable = 1'b0;
    result_ack = 1'b0;
    gap(2);
    reset = 1'b0;
  endtask

  task automatic wait_valid(input int lim, output int n);
    n = 0;
    while (!result_valid && n < lim) begin
      gap(1);
      n++;
    end
    chk("wait_valid", result_valid, 1);
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_valid"}, result_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_data"}, result_data, 0);
    chk({tag, "_ch"}, result_ch, 0);
    chk({tag, "_to"}, result_timeout, 0);
  endtask

  task automatic chk_res(input string tag, input int d, input int c,
                         input int t);
    chk({tag, "_data"}, result_data, d);
    chk({tag, "_ch"}, result_ch, c);
    chk({tag, "_to"}, result_timeout, t);
  endtask

  task automatic run_round(input int rnd);
    exp_t x;
    int k;
    for (int c = 0; c < NCH; c++) begin
      if (rnd == 0)      per[c] = 25 + 10 * c + ((c == 3) ? 40 : 0);
      else if (rnd == 1) per[c] = (c == 0) ? 0 : (c == 1) ? 180 : 158 + c;
      else per[c] = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(12, 200);
      ph[c] = $urandom_range(4, 60);
      hw[c] = (per[c] > 0) ? $urandom_range(2, per[c] - 2) : 2;
    end
    build_model();
    reset = 1'b1;
    pulse_in = '0;
    enable = 1'b1;
    result_ack = 1'b1;
    gap(2);
    k = 0;
    for (int u = 0; u < H; u++) begin
      if (u == 0) reset = 1'b0;
      for (int c = 0; c < NCH; c++) pulse_in[c] = pin_at(c, u);
      if (result_valid) begin
        if (q.size() == 0) begin
          chk("rr_extra", result_valid, 0);
        end else begin
          x = q.pop_front();
          chk("rr_pub", u, x.pub);
          chk_res("rr", x.data, x.ch, x.to);
          if (rnd == 0 && k < 4) chk("rr_hand", result_data, hand[k]);
          k++;
        end
      end
      gap(1);
    end
    chk("rr_left", q.size(), 0);
  endtask

  initial begin
    int n;
    int errs;
    gap(1);

    for (int r = 0; r < 4; r++) run_round(r);

    // handshake hold and ack release
    do_reset();
    chk_rst("rst");
    enable = 1'b1;
    gap(5);
    pulse(0);
    gap(52);
    pulse(0);
    wait_valid(10, n);
    chk("basic_lat", n, 0);
    chk_res("basic", 5, 0, 0);
    errs = 0;
    for (int i = 0; i < 200; i++) begin
      if (i == 50)  pulse_in[0] = 1'b1;
      if (i == 53)  pulse_in[0] = 1'b0;
      if (i == 100) pulse_in[1] = 1'b1;
      if (i == 103) pulse_in[1] = 1'b0;
      if (result_valid !== 1'b1 || result_data !== 4'd5 ||
          result_ch !== 2'd0 || busy !== 1'b1) errs++;
      gap(1);
    end
    chk("hold_stable", errs, 0);
    result_ack = 1'b1;
    gap(1);
    chk("ack_drop", result_valid, 0);
    chk("ack_busy", busy, 0);
    chk("keep_data", result_data, 5);
    result_ack = 1'b0;
    gap(2);
    pulse(1);
    gap(22);
    pulse(1);
    wait_valid(10, n);
    chk_res("next_ch", 2, 1, 0);

    // ARM and MEASURE timeouts
    do_reset();
    enable = 1'b1;
    result_ack = 1'b1;
    wait_valid(200, n);
    chk("arm_to_lat", n, 161);
    chk_res("arm_to", 15, 0, 1);
    gap(3);
    pulse(1);
    wait_valid(200, n);
    chk("meas_to_lat", n, 160);
    chk_res("meas_to", 15, 1, 1);

    // reset during PUBLISH and during MEASURE
    do_reset();
    enable = 1'b1;
    gap(3);
    pulse(0);
    gap(32);
    pulse(0);
    wait_valid(10, n);
    chk_res("pre_rst", 3, 0, 0);
    reset = 1'b1;
    gap(1);
    reset = 1'b0;
    chk_rst("rst_pub");
    result_ack = 1'b1;
    gap(3);
    pulse(0);
    gap(42);
    pulse(0);
    wait_valid(10, n);
    chk_res("post_rst", 4, 0, 0);
    result_ack = 1'b0;
    gap(3);
    pulse(1);
    gap(10);
    reset = 1'b1;
    gap(1);
    reset = 1'b0;
    chk_rst("rst_meas");
    gap(3);
    pulse(0);
    gap(22);
    pulse(0);
    wait_valid(10, n);
    chk_res("restart", 2, 0, 0);

    // stray ack and enable low
    do_reset();
    errs = 0;
    for (int i = 0; i < 120; i++) begin
      result_ack = 1'($urandom_range(0, 1));
      if (i % 20 == 5) pulse_in[0] = 1'b1;
      if (i % 20 == 8) pulse_in[0] = 1'b0;
      if (busy !== 1'b0 || result_valid !== 1'b0) errs++;
      gap(1);
    end
    chk("en_low_idle", errs, 0);
    result_ack = 1'b0;
    enable = 1'b1;
    gap(3);
    pulse(0);
    for (int i = 0; i < 20; i++) begin
      result_ack = 1'($urandom_range(0, 1));
      gap(1);
    end
    result_ack = 1'b0;
    enable = 1'b0;
    gap(32);
    pulse(0);
    wait_valid(10, n);
    chk_res("en_drop", 5, 0, 0);
    chk("en_drop_busy", busy, 1);
    result_ack = 1'b1;
    gap(1);
    errs = 0;
    for (int i = 0; i < 100; i++) begin
      if (i % 25 == 3) pulse_in[1] = 1'b1;
      if (i % 25 == 6) pulse_in[1] = 1'b0;
      if (busy !== 1'b0 || result_valid !== 1'b0) errs++;
      gap(1);
    end
    chk("en_low_after", errs, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
